// File: rtl/rsa_job_scheduler_if.sv
// Requester-side bus of rsa_job_scheduler: per-channel requests and operands,
// plus the ack/done/result/status returned by the scheduler.
interface rsa_job_scheduler_if #(
    parameter int DW = 256
);
    logic [1:0]    i_req;
    logic [DW-1:0] i_a0;
    logic [DW-1:0] i_d0;
    logic [DW-1:0] i_n0;
    logic [DW-1:0] i_a1;
    logic [DW-1:0] i_d1;
    logic [DW-1:0] i_n1;
    logic [1:0]    o_ack;
    logic [1:0]    o_done;
    logic [DW-1:0] o_result;
    logic          o_err;
    logic          o_busy;

    modport slave (
        input  i_req, i_a0, i_d0, i_n0, i_a1, i_d1, i_n1,
        output o_ack, o_done, o_result, o_err, o_busy
    );

    modport master (
        output i_req, i_a0, i_d0, i_n0, i_a1, i_d1, i_n1,
        input  o_ack, o_done, o_result, o_err, o_busy
    );
endinterface

// File: rtl/rsa_job_scheduler.sv
// Round-robin sharing of one Rsa256Core between two requester channels.
// Optional RSA_TIMEOUT_EN adds a WAIT-state watchdog that aborts a hung core.
module rsa_job_scheduler #(
    parameter int DW          = 256,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    rsa_job_scheduler_if.slave   req_if,
    output logic                 o_core_start,
    output logic [DW-1:0]        o_core_a,
    output logic [DW-1:0]        o_core_d,
    output logic [DW-1:0]        o_core_n,
    output logic                 o_core_rst,
    input  logic [DW-1:0]        i_core_result,
    input  logic                 i_core_finished
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
`ifdef RSA_TIMEOUT_EN
        S_ABORT  = 3'd4,
`endif
        S_GAP    = 3'd3
    } state_t;

    state_t        state_r, state_next_s;
    logic          grant_r, grant_next_s;
    logic          last_r, last_next_s;
    logic          g_s;
    logic [DW-1:0] core_a_r, core_a_next_s;
    logic [DW-1:0] core_d_r, core_d_next_s;
    logic [DW-1:0] core_n_r, core_n_next_s;
    logic [DW-1:0] result_r, result_next_s;
    logic [1:0]    ack_r, ack_next_s;
    logic [1:0]    done_r, done_next_s;
    logic          start_r, start_next_s;
    logic          busy_r, busy_next_s;
`ifdef RSA_TIMEOUT_EN
    logic [31:0]   cnt_r, cnt_next_s;
    logic          abort_cnt_r, abort_cnt_next_s;
    logic          err_r, err_next_s;
    logic          core_rst_r, core_rst_next_s;
`endif

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_next_s  = state_r;
        grant_next_s  = grant_r;
        last_next_s   = last_r;
        g_s           = 1'b0;
        core_a_next_s = core_a_r;
        core_d_next_s = core_d_r;
        core_n_next_s = core_n_r;
        result_next_s = result_r;
        ack_next_s    = 2'b00;
        done_next_s   = 2'b00;
        start_next_s  = 1'b0;
`ifdef RSA_TIMEOUT_EN
        cnt_next_s       = cnt_r;
        abort_cnt_next_s = abort_cnt_r;
        err_next_s       = 1'b0;
`endif
        case (state_r)
            S_IDLE: begin
                if (req_if.i_req != 2'b00) begin
                    // On a tie the channel not served last wins.
                    if (req_if.i_req == 2'b11) begin
                        g_s = ~last_r;
                    end else begin
                        g_s = req_if.i_req[1];
                    end
                    grant_next_s = g_s;
                    last_next_s  = g_s;
                    if (g_s) begin
                        core_a_next_s = req_if.i_a1;
                        core_d_next_s = req_if.i_d1;
                        core_n_next_s = req_if.i_n1;
                        ack_next_s    = 2'b10;
                    end else begin
                        core_a_next_s = req_if.i_a0;
                        core_d_next_s = req_if.i_d0;
                        core_n_next_s = req_if.i_n0;
                        ack_next_s    = 2'b01;
                    end
                    state_next_s = S_LAUNCH;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_LAUNCH: begin
                start_next_s = 1'b1;
`ifdef RSA_TIMEOUT_EN
                cnt_next_s   = 32'd0;
`endif
                state_next_s = S_WAIT;
            end
            S_WAIT: begin
                if (i_core_finished) begin
                    result_next_s = i_core_result;
                    done_next_s   = grant_r ? 2'b10 : 2'b01;
                    state_next_s  = S_GAP;
`ifdef RSA_TIMEOUT_EN
                end else if (cnt_r == 32'(TIMEOUT_CYC - 1)) begin
                    abort_cnt_next_s = 1'b0;
                    state_next_s     = S_ABORT;
                end else begin
                    cnt_next_s   = cnt_r + 32'd1;
                    state_next_s = S_WAIT;
`else
                end else begin
                    state_next_s = S_WAIT;
`endif
                end
            end
            S_GAP: begin
                state_next_s = S_IDLE;
            end
`ifdef RSA_TIMEOUT_EN
            S_ABORT: begin
                if (abort_cnt_r) begin
                    result_next_s = {DW{1'b0}};
                    done_next_s   = grant_r ? 2'b10 : 2'b01;
                    err_next_s    = 1'b1;
                    state_next_s  = S_GAP;
                end else begin
                    abort_cnt_next_s = 1'b1;
                    state_next_s     = S_ABORT;
                end
            end
`endif
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
        busy_next_s = (state_next_s != S_IDLE);
`ifdef RSA_TIMEOUT_EN
        core_rst_next_s = (state_next_s == S_ABORT);
`endif
    end

    // State, holding registers and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= S_IDLE;
            grant_r  <= 1'b0;
            last_r   <= 1'b1;
            core_a_r <= {DW{1'b0}};
            core_d_r <= {DW{1'b0}};
            core_n_r <= {DW{1'b0}};
            result_r <= {DW{1'b0}};
            ack_r    <= 2'b00;
            done_r   <= 2'b00;
            start_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            grant_r  <= grant_next_s;
            last_r   <= last_next_s;
            core_a_r <= core_a_next_s;
            core_d_r <= core_d_next_s;
            core_n_r <= core_n_next_s;
            result_r <= result_next_s;
            ack_r    <= ack_next_s;
            done_r   <= done_next_s;
            start_r  <= start_next_s;
            busy_r   <= busy_next_s;
        end
    end

`ifdef RSA_TIMEOUT_EN
    // Watchdog counter and abort sequencing registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r       <= 32'd0;
            abort_cnt_r <= 1'b0;
            err_r       <= 1'b0;
            core_rst_r  <= 1'b0;
        end else begin
            cnt_r       <= cnt_next_s;
            abort_cnt_r <= abort_cnt_next_s;
            err_r       <= err_next_s;
            core_rst_r  <= core_rst_next_s;
        end
    end

    assign req_if.o_err = err_r;
    assign o_core_rst   = core_rst_r;
`else
    assign req_if.o_err = 1'b0;
    assign o_core_rst   = 1'b0;
`endif

    assign req_if.o_ack    = ack_r;
    assign req_if.o_done   = done_r;
    assign req_if.o_result = result_r;
    assign req_if.o_busy   = busy_r;
    assign o_core_start    = start_r;
    assign o_core_a        = core_a_r;
    assign o_core_d        = core_d_r;
    assign o_core_n        = core_n_r;

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Directed bench for rsa_job_scheduler with a behavioural stand-in core.
// Define RSA_TIMEOUT_EN to also exercise the watchdog abort path.
module tb_rsa_job_scheduler;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_start, core_rst;
    logic [DW-1:0] core_a, core_d, core_n;
    logic [DW-1:0] core_result;
    logic          core_finished;

    int checks = 0;
    int errors = 0;

    // stand-in core state
    int            lat_cfg = 20;
    int            model_cnt;
    logic          model_busy;
    logic          model_fin;
    logic [DW-1:0] model_res;
    logic          force_fin = 1'b0;

    rsa_job_scheduler_if #(.DW(DW)) bus ();

    rsa_job_scheduler #(
        .DW(DW)
`ifdef RSA_TIMEOUT_EN
        , .TIMEOUT_CYC(100)
`endif
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .req_if          (bus),
        .o_core_start    (core_start),
        .o_core_a        (core_a),
        .o_core_d        (core_d),
        .o_core_n        (core_n),
        .o_core_rst      (core_rst),
        .i_core_result   (core_result),
        .i_core_finished (core_finished)
    );

    always #5 clk = ~clk;

    assign core_finished = model_fin | force_fin;
    assign core_result   = force_fin ? 256'd99 : model_res;

    function automatic logic [DW-1:0] modexp(input logic [DW-1:0] a, input logic [DW-1:0] d,
                                             input logic [DW-1:0] n);
        longint unsigned r = 1, b, e, m;
        b = longint'(a[31:0]);
        e = longint'(d[31:0]);
        m = longint'(n[31:0]);
        if (m == 0) return '0;
        b = b % m;
        while (e != 0) begin
            if (e[0]) r = (r * b) % m;
            b = (b * b) % m;
            e = e >> 1;
        end
        return DW'(r);
    endfunction

    // Stand-in core: fixed latency after start, lat_cfg==0 means never finishes.
    always @(posedge clk) begin
        if (rst || core_rst) begin
            model_busy <= 1'b0;
            model_fin  <= 1'b0;
            model_cnt  <= 0;
            model_res  <= '0;
        end else begin
            model_fin <= 1'b0;
            if (core_start) begin
                model_busy <= 1'b1;
                model_cnt  <= 0;
                model_res  <= modexp(core_a, core_d, core_n);
            end else if (model_busy) begin
                if (lat_cfg != 0 && model_cnt == lat_cfg) begin
                    model_fin  <= 1'b1;
                    model_busy <= 1'b0;
                end else begin
                    model_cnt <= model_cnt + 1;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string tag, output logic [1:0] a);
        a = 2'b00;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.o_ack != 2'b00) begin
                a = bus.o_ack;
                break;
            end
        end
        check_eq({tag, "_ack_seen"}, DW'(a != 2'b00), DW'(1'b1));
    endtask

    task automatic wait_done(input string tag, output logic [1:0] d);
        d = 2'b00;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (bus.o_done != 2'b00) begin
                d = bus.o_done;
                break;
            end
        end
        check_eq({tag, "_done_seen"}, DW'(d != 2'b00), DW'(1'b1));
    endtask

    task automatic set_ops();
        bus.i_a0 = 256'd2; bus.i_d0 = 256'd10; bus.i_n0 = 256'd77;
        bus.i_a1 = 256'd3; bus.i_d1 = 256'd5;  bus.i_n1 = 256'd77;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, DW'({bus.o_ack, bus.o_done, bus.o_err, bus.o_busy, core_start, core_rst}), '0);
        check_eq({tag, "_result"}, bus.o_result, '0);
        check_eq({tag, "_ops"}, core_a | core_d | core_n, '0);
    endtask

    initial begin
        logic [1:0] a, d;
        logic [1:0] order [4];
        bus.i_req = 2'b00;
        set_ops();

        // reset state
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;

        // 1: single request on channel 0
        bus.i_req = 2'b01;
        tick();
        check_eq("t1_ack", DW'(bus.o_ack), DW'(2'b01));
        check_eq("t1_busy", DW'(bus.o_busy), DW'(1'b1));
        check_eq("t1_start_not_yet", DW'(core_start), DW'(1'b0));
        bus.i_req = 2'b00;
        tick();
        check_eq("t1_start", DW'(core_start), DW'(1'b1));
        check_eq("t1_core_a", core_a, 256'd2);
        check_eq("t1_core_d", core_d, 256'd10);
        check_eq("t1_core_n", core_n, 256'd77);
        tick();
        check_eq("t1_start_pulse", DW'(core_start), DW'(1'b0));
        wait_done("t1", d);
        check_eq("t1_done", DW'(d), DW'(2'b01));
        check_eq("t1_result", bus.o_result, 256'd23);
        check_eq("t1_err", DW'(bus.o_err), DW'(1'b0));

        // 2: simultaneous requests after reset
        rst = 1'b1; tick(); rst = 1'b0;
        bus.i_req = 2'b11;
        tick();
        check_eq("t2_ack0", DW'(bus.o_ack), DW'(2'b01));
        bus.i_req = 2'b10;
        wait_done("t2a", d);
        check_eq("t2_done0", DW'(d), DW'(2'b01));
        check_eq("t2_result0", bus.o_result, 256'd23);
        tick();
        check_eq("t2_no_ack_yet", DW'(bus.o_ack), DW'(2'b00));
        tick();
        check_eq("t2_ack1", DW'(bus.o_ack), DW'(2'b10));
        bus.i_req = 2'b00;
        wait_done("t2b", d);
        check_eq("t2_done1", DW'(d), DW'(2'b10));
        check_eq("t2_result1", bus.o_result, 256'd12);

        // 3: both channels re-request after every done
        bus.i_req = 2'b11;
        for (int j = 0; j < 4; j++) begin
            wait_ack("t3", a);
            check_eq("t3_ack_onehot", DW'($countones(a)), DW'(1));
            order[j] = a;
            bus.i_req = bus.i_req & ~a;
            wait_done("t3", d);
            check_eq("t3_done_match", DW'(d), DW'(a));
            bus.i_req = (j == 3) ? 2'b00 : 2'b11;
        end
        check_eq("t3_order", DW'({order[0], order[1], order[2], order[3]}), DW'(8'b01_10_01_10));

        // 4: reset deep inside WAIT
        tick();
        lat_cfg = 0;
        bus.i_req = 2'b10;
        wait_ack("t4", a);
        bus.i_req = 2'b00;
        tick();
        check_eq("t4_start", DW'(core_start), DW'(1'b1));
        for (int i = 0; i < 1000; i++) tick();
        check_eq("t4_busy_wait", DW'(bus.o_busy), DW'(1'b1));
        rst = 1'b1;
        tick();
        check_all_zero("t4_rst");
        rst = 1'b0;
        lat_cfg = 20;
        bus.i_req = 2'b11;
        tick();
        check_eq("t4_ack0_first", DW'(bus.o_ack), DW'(2'b01));
        bus.i_req = 2'b10;
        wait_done("t4a", d);
        check_eq("t4_result0", bus.o_result, 256'd23);
        wait_ack("t4b", a);
        check_eq("t4_ack1", DW'(a), DW'(2'b10));
        bus.i_req = 2'b00;
        wait_done("t4b", d);
        check_eq("t4_result1", bus.o_result, 256'd12);

        // 5: stray finished in IDLE and LAUNCH is ignored
        tick(); tick();
        force_fin = 1'b1;
        tick(); tick();
        check_eq("t5_idle_done", DW'(bus.o_done), DW'(2'b00));
        check_eq("t5_idle_result", bus.o_result, 256'd12);
        force_fin = 1'b0;
        bus.i_req = 2'b01;
        tick();
        check_eq("t5_ack", DW'(bus.o_ack), DW'(2'b01));
        bus.i_req = 2'b00;
        force_fin = 1'b1;
        tick();
        force_fin = 1'b0;
        tick();
        check_eq("t5_launch_done", DW'(bus.o_done), DW'(2'b00));
        check_eq("t5_launch_result", bus.o_result, 256'd12);
        wait_done("t5", d);
        check_eq("t5_result", bus.o_result, 256'd23);

`ifdef RSA_TIMEOUT_EN
        // 6: watchdog abort, then a normal job
        begin
            int n = 0;
            tick();
            lat_cfg = 0;
            bus.i_req = 2'b01;
            wait_ack("t6", a);
            bus.i_req = 2'b00;
            tick();
            check_eq("t6_start", DW'(core_start), DW'(1'b1));
            for (int i = 0; i < 300; i++) begin
                tick();
                n++;
                if (core_rst) break;
            end
            check_eq("t6_wait_cycles", DW'(n), DW'(100));
            check_eq("t6_core_rst0", DW'(core_rst), DW'(1'b1));
            tick();
            check_eq("t6_core_rst1", DW'(core_rst), DW'(1'b1));
            tick();
            check_eq("t6_core_rst_end", DW'(core_rst), DW'(1'b0));
            check_eq("t6_done", DW'(bus.o_done), DW'(2'b01));
            check_eq("t6_err", DW'(bus.o_err), DW'(1'b1));
            check_eq("t6_result", bus.o_result, '0);
            lat_cfg = 20;
            bus.i_req = 2'b01;
            wait_ack("t6b", a);
            bus.i_req = 2'b00;
            wait_done("t6b", d);
            check_eq("t6b_result", bus.o_result, 256'd23);
            check_eq("t6b_err", DW'(bus.o_err), DW'(1'b0));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
